mimc_hash_mp_ctrl: RTL and testbench

//  Miyaguchi-Preneel MiMC hash engine over the BN254 scalar field. Accepts a stream of field-element

---
 rtl/mimc_hash_mp_ctrl_pkg.sv | 48 ++++
 rtl/mimc_hash_mp_ctrl_cipher.sv | 85 ++++++++
 rtl/mimc_hash_mp_ctrl.sv | 108 ++++++++++
 tb/tb_mimc_hash_mp_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mimc_hash_mp_ctrl_pkg.sv
// Shared definitions for the Miyaguchi-Preneel MiMC hash engine: BN254 field constants,
// FSM encodings and the modular add/multiply helpers used by the controller and the cipher.
package mimc_hash_mp_ctrl_pkg;

  localparam int N_BITS = 254;
  localparam int ROUNDS = 91;

  localparam logic [255:0] P_W =
    256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
  localparam logic [N_BITS-1:0] MODULUS = P_W[N_BITS-1:0];

  // Barrett constant floor(2^(2*N_BITS) / p); fits in N_BITS+1 bits since p > 2^253.
  localparam logic [511:0] MU_W = (512'd1 << 508) / {256'd0, P_W};
  localparam logic [255:0] MU   = MU_W[255:0];

  // Round constant i is i * floor(p/128): always below p for i < 128, so no reduction.
  localparam logic [N_BITS-1:0] RC_STEP = N_BITS'(P_W >> 7);

  typedef enum logic [2:0] {IDLE, START, WAIT, ADD1, ADD2, OUT} hash_state_e;
  typedef enum logic [1:0] {C_IDLE, C_ADD, C_MUL, C_FIN} cipher_state_e;

  function automatic logic [N_BITS-1:0] add_mod(input logic [N_BITS-1:0] a,
                                                input logic [N_BITS-1:0] b);
    logic [N_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, MODULUS}) s = s - {1'b0, MODULUS};
    return s[N_BITS-1:0];
  endfunction

  function automatic logic [N_BITS-1:0] mul_mod(input logic [N_BITS-1:0] a,
                                                input logic [N_BITS-1:0] b);
    logic [511:0] x;
    logic [511:0] q;
    logic [511:0] r;
    x = {258'd0, a} * {258'd0, b};
    q = ({257'd0, x[507:253]} * {256'd0, MU}) >> 255;
    r = x - q * {258'd0, MODULUS};
    // Barrett leaves r < 3p: two conditional subtractions finish the reduction.
    if (r >= {258'd0, MODULUS}) r = r - {258'd0, MODULUS};
    if (r >= {258'd0, MODULUS}) r = r - {258'd0, MODULUS};
    return r[N_BITS-1:0];
  endfunction

  function automatic logic [N_BITS-1:0] round_const(input logic [6:0] r);
    return RC_STEP * {{(N_BITS-7){1'b0}}, r};
  endfunction

endpackage

// File: rtl/mimc_hash_mp_ctrl_cipher.sv
// MiMC-p/p block cipher, x^7 over 91 rounds: x <- (x + k + c_i)^7, out = x + k.
// One Barrett multiplier is time-shared over four steps per round (t^2, t^4, t^6, t^7).
module mimc_cipher
  import mimc_hash_mp_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_BITS-1:0] in,
  input  logic [N_BITS-1:0] key,
  output logic [N_BITS-1:0] out,
  output logic              done
);

  cipher_state_e     cstate;
  logic [N_BITS-1:0] x, k, t, a, b;
  logic [N_BITS-1:0] ma, mb, prod;
  logic [6:0]        round;
  logic [1:0]        step;

  always_comb begin
    ma = t;
    mb = t;
    case (step)
      2'd0:    begin ma = t; mb = t; end
      2'd1:    begin ma = a; mb = a; end
      2'd2:    begin ma = b; mb = a; end
      default: begin ma = b; mb = t; end
    endcase
    prod = mul_mod(ma, mb);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cstate <= C_IDLE;
      x      <= '0;
      k      <= '0;
      t      <= '0;
      a      <= '0;
      b      <= '0;
      round  <= '0;
      step   <= '0;
      out    <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (cstate)
        C_IDLE: if (en) begin
          x      <= in;
          k      <= key;
          round  <= '0;
          cstate <= C_ADD;
        end
        C_ADD: begin
          t      <= add_mod(add_mod(x, k), round_const(round));
          step   <= '0;
          cstate <= C_MUL;
        end
        C_MUL: begin
          step <= step + 2'd1;
          case (step)
            2'd0: a <= prod;
            2'd1: b <= prod;
            2'd2: b <= prod;
            default: begin
              x <= prod;
              if (round == 7'(ROUNDS - 1)) cstate <= C_FIN;
              else begin
                round  <= round + 7'd1;
                cstate <= C_ADD;
              end
            end
          endcase
        end
        C_FIN: begin
          out    <= add_mod(x, k);
          done   <= 1'b1;
          cstate <= C_IDLE;
        end
        default: cstate <= C_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mimc_hash_mp_ctrl.sv
// Miyaguchi-Preneel chaining around the MiMC cipher: h_i = E_{h_(i-1)}(m_i) + h_(i-1) + m_i mod p.
// IDLE accept block | START pulse cipher en | WAIT cipher done | ADD1 s=c+h | ADD2 h=s+m | OUT hold digest
module mimc_hash_mp_ctrl
  import mimc_hash_mp_ctrl_pkg::*;
#(
  parameter logic [N_BITS-1:0] IV = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              msg_valid,
  output logic              msg_ready,
  input  logic [N_BITS-1:0] msg_data,
  input  logic              msg_last,
  output logic              hash_valid,
  input  logic              hash_ready,
  output logic [N_BITS-1:0] hash_out,
  output logic              err
);

  hash_state_e       state;
  logic [N_BITS-1:0] m, h, c, s;
  logic              last;
  logic              cipher_en, cipher_done, cipher_rst;
  logic [N_BITS-1:0] cipher_out;
  logic [N_BITS-1:0] add_a, add_b, add_res;

  assign cipher_rst = ~rst;

  mimc_cipher u_cipher (
    .clk  (clk),
    .rst  (cipher_rst),
    .en   (cipher_en),
    .in   (m),
    .key  (h),
    .out  (cipher_out),
    .done (cipher_done)
  );

  // Single modular adder shared by both chaining additions.
  always_comb begin
    add_a   = (state == ADD1) ? c : s;
    add_b   = (state == ADD1) ? h : m;
    add_res = add_mod(add_a, add_b);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      h          <= IV;
      m          <= '0;
      c          <= '0;
      s          <= '0;
      last       <= 1'b0;
      msg_ready  <= 1'b0;
      hash_valid <= 1'b0;
      hash_out   <= '0;
      err        <= 1'b0;
      cipher_en  <= 1'b0;
    end else begin
      err       <= 1'b0;
      cipher_en <= 1'b0;
      case (state)
        IDLE: begin
          msg_ready <= 1'b1;
          if (msg_valid && msg_ready) begin
            if (msg_data < MODULUS) begin
              m         <= msg_data;
              last      <= msg_last;
              msg_ready <= 1'b0;
              cipher_en <= 1'b1;
              state     <= START;
            end else begin
              err <= 1'b1;
            end
          end
        end
        START: state <= WAIT;
        WAIT: if (cipher_done) begin
          c     <= cipher_out;
          state <= ADD1;
        end
        ADD1: begin
          s     <= add_res;
          state <= ADD2;
        end
        ADD2: begin
          h <= add_res;
          if (last) begin
            hash_out   <= add_res;
            hash_valid <= 1'b1;
            state      <= OUT;
          end else begin
            msg_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        OUT: if (hash_ready) begin
          hash_valid <= 1'b0;
          h          <= IV;
          msg_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mimc_hash_mp_ctrl.sv
// Bench for mimc_hash_mp_ctrl: directed and random messages against a plain-arithmetic
// MiMC / Miyaguchi-Preneel reference model.
module tb_mimc_hash_mp_ctrl;

  localparam logic [511:0] P =
    {256'd0, 256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001};
  localparam int TMO = 1000;

  logic         clk = 1'b0;
  logic         rst;
  logic         msg_valid, msg_ready, msg_last;
  logic [253:0] msg_data;
  logic         hash_valid, hash_ready, err;
  logic [253:0] hash_out;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  logic [511:0] q[$];
  logic [511:0] ref_h0;

  always #5 clk = ~clk;

  mimc_hash_mp_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .msg_valid  (msg_valid),
    .msg_ready  (msg_ready),
    .msg_data   (msg_data),
    .msg_last   (msg_last),
    .hash_valid (hash_valid),
    .hash_ready (hash_ready),
    .hash_out   (hash_out),
    .err        (err)
  );

  always @(posedge clk) if (dut.cipher_en === 1'b1) en_cnt++;

  initial begin
    #600000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference model: field arithmetic by plain % on wide integers.
  function automatic logic [511:0] pow7(input logic [511:0] t);
    logic [511:0] y;
    y = 512'd1;
    for (int j = 0; j < 7; j++) y = (y * t) % P;
    return y;
  endfunction

  function automatic logic [511:0] mimc_ref(input logic [511:0] msg, input logic [511:0] key);
    logic [511:0] x;
    x = msg;
    for (int i = 0; i < 91; i++) x = pow7((x + key + (P >> 7) * 512'(i)) % P);
    return (x + key) % P;
  endfunction

  function automatic logic [511:0] rand_fe();
    logic [511:0] v;
    v = '0;
    for (int j = 0; j < 8; j++) v = (v << 32) | 512'($urandom);
    return v % P;
  endfunction

  task automatic send_block(input logic [253:0] d, input logic l);
    int n;
    n = 0;
    while (!msg_ready && n < TMO) begin @(negedge clk); n++; end
    chk("rdy_wait", 256'(msg_ready), 256'd1);
    msg_valid = 1'b1;
    msg_data  = d;
    msg_last  = l;
    @(negedge clk);
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    if ({258'd0, d} < P) begin
      chk("acc_busy", 256'(msg_ready), 256'd0);
      chk("acc_noerr", 256'(err), 256'd0);
    end else begin
      chk("rej_err", 256'(err), 256'd1);
      chk("rej_rdy", 256'(msg_ready), 256'd1);
      @(negedge clk);
      chk("rej_pulse", 256'(err), 256'd0);
    end
  endtask

  task automatic get_hash(input logic [511:0] exp, input string tag, input int hold);
    int n;
    n = 0;
    while (!hash_valid && n < TMO) begin @(negedge clk); n++; end
    chk({tag, "_vld"}, 256'(hash_valid), 256'd1);
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold"}, {hash_valid, msg_ready, hash_out}, {1'b1, 1'b0, exp[253:0]});
      @(negedge clk);
    end
    chk(tag, 256'(hash_out), exp[255:0]);
    hash_ready = 1'b1;
    @(negedge clk);
    hash_ready = 1'b0;
    chk({tag, "_clr"}, 256'({hash_valid, msg_ready}), 256'd1);
  endtask

  task automatic run_msg(input logic [511:0] blks[$], input string tag, input int hold);
    logic [511:0] h;
    h = '0;
    foreach (blks[i]) begin
      send_block(blks[i][253:0], (i == blks.size() - 1));
      if (blks[i] < P) h = (mimc_ref(blks[i], h) + h + blks[i]) % P;
    end
    get_hash(h, tag, hold);
  endtask

  initial begin
    int e0;
    rst = 1'b0;
    msg_valid = 1'b0;
    msg_data = '0;
    msg_last = 1'b0;
    hash_ready = 1'b0;
    #1;
    chk("rst_out", 256'({msg_ready, hash_valid, err, hash_out}), 256'd0);
    repeat (3) @(negedge clk);
    chk("rst_hold", 256'({msg_ready, hash_valid, err, hash_out}), 256'd0);
    rst = 1'b1;

    // Single block m=0 against E_0(0) computed directly
    ref_h0 = (mimc_ref(512'd0, 512'd0) + 512'd0 + 512'd0) % P;
    send_block('0, 1'b1);
    get_hash(ref_h0, "single0", 3);

    q.delete(); q.push_back(512'd1); q.push_back(512'd2); q.push_back(512'd3);
    run_msg(q, "three", 0);

    // Block equal to p is rejected without touching the cipher or the chain
    e0 = en_cnt;
    send_block(P[253:0], 1'b0);
    repeat (2) @(negedge clk);
    chk("rej_no_en", 256'(en_cnt - e0), 256'd0);
    q.delete(); q.push_back(512'd5);
    run_msg(q, "after_rej", 0);

    q.delete(); q.push_back(512'd7);
    run_msg(q, "backpress", 10);
    send_block('0, 1'b1);
    get_hash(ref_h0, "from_iv", 0);

    // Reset while block 2 is in the cipher
    send_block(254'd11, 1'b0);
    send_block(254'd22, 1'b1);
    repeat (30) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_out", 256'({msg_ready, hash_valid, err, hash_out}), 256'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    q.delete(); q.push_back(512'd11); q.push_back(512'd22);
    run_msg(q, "resend", 0);

    q.delete(); q.push_back(P - 1); q.push_back(P - 1); q.push_back(P - 1);
    run_msg(q, "wrap", 0);

    // Random messages with occasional out-of-field blocks
    for (int r = 0; r < 4; r++) begin
      int len;
      len = $urandom_range(1, 3);
      q.delete();
      for (int b = 0; b < len; b++) begin
        if (b < len - 1 && $urandom_range(0, 3) == 0)
          q.push_back(($urandom_range(0, 1) == 0) ? P + 512'($urandom_range(0, 1000))
                                                  : (512'd1 << 254) - 512'd1);
        q.push_back(rand_fe());
      end
      run_msg(q, "rand", $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
